// File: rtl/mux_cfgchain_param.sv
// Configurable N:1 mux whose select is loaded through a serial configuration chain.
// A shift register fills from ccff_head and is committed to a shadow register on a legal update.
module mux_cfgchain_param #(
  parameter int NUM_INPUTS = 8,
  parameter int ENCODING   = 0,
  parameter int OUT_REG    = 0,
  localparam int MEM_SIZE  = (ENCODING == 0) ? NUM_INPUTS : $clog2(NUM_INPUTS),
  localparam int CNT_W     = $clog2(MEM_SIZE + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic                  ccff_head,
  output logic                  ccff_tail,
  input  logic                  shift_en,
  input  logic                  update,
  input  logic [NUM_INPUTS-1:0] in,
  output logic [MEM_SIZE-1:0]   mem,
  output logic [MEM_SIZE-1:0]   mem_inv,
  output logic                  out,
  output logic                  cfg_valid,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      shift_cnt
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_SIZE);

  logic [MEM_SIZE-1:0] sreg;
  logic [MEM_SIZE-1:0] shadow;
  logic [MEM_SIZE:0]   sreg_ext;
  logic                legal;
  logic                accept;
  logic                sel_raw;
  logic                sel;

  // Appending ccff_head below sreg keeps the shift well-formed even when MEM_SIZE is 1.
  assign sreg_ext  = {sreg, ccff_head};
  assign ccff_tail = sreg[MEM_SIZE-1];
  assign mem       = shadow;
  assign mem_inv   = ~shadow;
  assign accept    = update && !shift_en && (shift_cnt == CNT_FULL) && legal;

  generate
    if (ENCODING == 0) begin : g_onehot
      assign legal   = ($countones(sreg) == 1);
      assign sel_raw = |(in & shadow);
    end else begin : g_binary
      localparam logic [MEM_SIZE:0] LIMIT = (MEM_SIZE + 1)'(NUM_INPUTS);
      assign legal   = ({1'b0, sreg} < LIMIT);
      assign sel_raw = in[shadow];
    end
  endgenerate

  assign sel = sel_raw & cfg_valid;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sreg      <= '0;
      shadow    <= '0;
      shift_cnt <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (shift_en) begin
      sreg <= sreg_ext[MEM_SIZE-1:0];
      if (shift_cnt != CNT_FULL) shift_cnt <= shift_cnt + 1'b1;
      // An update colliding with a shift is dropped and flagged.
      if (update) cfg_err <= 1'b1;
    end else if (update) begin
      if (accept) begin
        shadow    <= sreg;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
        shift_cnt <= '0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic out_q;
      always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) out_q <= 1'b0;
        else           out_q <= sel;
      end
      assign out = out_q;
    end else begin : g_out_comb
      assign out = sel;
    end
  endgenerate

endmodule

// File: tb/tb_mux_cfgchain_param.sv
// Directed bench for mux_cfgchain_param: one-hot/comb, binary/comb and binary/registered instances
// sharing clock and reset.
module tb_mux_cfgchain_param;

  logic prog_clk;
  logic pReset_n;
  int   checks;
  int   errors;

  // u0: NUM_INPUTS=8, one-hot, combinational
  logic       head0, sen0, upd0, tail0, out0, valid0, err0;
  logic [7:0] in0, mem0, inv0;
  logic [3:0] cnt0;
  // u1: NUM_INPUTS=6, binary, combinational
  logic       head1, sen1, upd1, tail1, out1, valid1, err1;
  logic [5:0] in1;
  logic [2:0] mem1, inv1;
  logic [1:0] cnt1;
  // u2: NUM_INPUTS=8, binary, registered
  logic       head2, sen2, upd2, tail2, out2, valid2, err2;
  logic [7:0] in2;
  logic [2:0] mem2, inv2;
  logic [1:0] cnt2;

  mux_cfgchain_param #(.NUM_INPUTS(8), .ENCODING(0), .OUT_REG(0)) u0 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .ccff_head(head0), .ccff_tail(tail0),
    .shift_en(sen0), .update(upd0), .in(in0), .mem(mem0), .mem_inv(inv0), .out(out0),
    .cfg_valid(valid0), .cfg_err(err0), .shift_cnt(cnt0));

  mux_cfgchain_param #(.NUM_INPUTS(6), .ENCODING(1), .OUT_REG(0)) u1 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .ccff_head(head1), .ccff_tail(tail1),
    .shift_en(sen1), .update(upd1), .in(in1), .mem(mem1), .mem_inv(inv1), .out(out1),
    .cfg_valid(valid1), .cfg_err(err1), .shift_cnt(cnt1));

  mux_cfgchain_param #(.NUM_INPUTS(8), .ENCODING(1), .OUT_REG(1)) u2 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .ccff_head(head2), .ccff_tail(tail2),
    .shift_en(sen2), .update(upd2), .in(in2), .mem(mem2), .mem_inv(inv2), .out(out2),
    .cfg_valid(valid2), .cfg_err(err2), .shift_cnt(cnt2));

  // Clock/reset
  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift the low n bits of v, MSB first, into instance 'which'; returns 1 ns after the edge.
  task automatic shift_bits(input int which, input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      case (which)
        0: begin head0 = v[i]; sen0 = 1'b1; end
        1: begin head1 = v[i]; sen1 = 1'b1; end
        default: begin head2 = v[i]; sen2 = 1'b1; end
      endcase
      @(posedge prog_clk); #1;
      sen0 = 1'b0; sen1 = 1'b0; sen2 = 1'b0;
    end
  endtask

  task automatic commit(input int which);
    case (which)
      0: upd0 = 1'b1;
      1: upd1 = 1'b1;
      default: upd2 = 1'b1;
    endcase
    @(posedge prog_clk); #1;
    upd0 = 1'b0; upd1 = 1'b0; upd2 = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    checks = 0;
    errors = 0;
    pReset_n = 1'b0;
    head0 = 0; sen0 = 0; upd0 = 0; in0 = 8'hFF;
    head1 = 0; sen1 = 0; upd1 = 0; in1 = 6'h3F;
    head2 = 0; sen2 = 0; upd2 = 0; in2 = 8'h00;

    // Reset state
    #12;
    chk("rst_mem0", mem0, 8'h00);
    chk("rst_inv0", inv0, 8'hFF);
    chk("rst_out0", out0, 1'b0);
    chk("rst_tail0", tail0, 1'b0);
    chk("rst_valid0", valid0, 1'b0);
    chk("rst_err0", err0, 1'b0);
    chk("rst_cnt0", cnt0, 4'd0);
    chk("rst_inv1", inv1, 3'b111);
    @(posedge prog_clk); #1;
    pReset_n = 1'b1;

    // One-hot commit of select 2
    shift_bits(0, 8'h04, 8);
    chk("oh_cnt_full", cnt0, 4'd8);
    chk("oh_out_invalid", out0, 1'b0);
    commit(0);
    chk("oh_mem", mem0, 8'h04);
    chk("oh_inv", inv0, 8'hFB);
    chk("oh_valid", valid0, 1'b1);
    chk("oh_cnt_clr", cnt0, 4'd0);
    chk("oh_out_hi", out0, 1'b1);
    in0 = 8'hFB; #1;
    chk("oh_out_lo", out0, 1'b0);

    // Update colliding with the 8th shift, then a lone update
    shift_bits(0, 8'h40, 7);
    head0 = 1'b0; sen0 = 1'b1; upd0 = 1'b1;
    @(posedge prog_clk); #1;
    sen0 = 1'b0; upd0 = 1'b0;
    chk("sim_cnt", cnt0, 4'd8);
    chk("sim_err", err0, 1'b1);
    chk("sim_mem_kept", mem0, 8'h04);
    commit(0);
    chk("sim_commit_mem", mem0, 8'h80);
    chk("sim_commit_err", err0, 1'b0);
    chk("sim_commit_cnt", cnt0, 4'd0);
    in0 = 8'h80; #1;
    chk("sim_out7_hi", out0, 1'b1);
    in0 = 8'h7F; #1;
    chk("sim_out7_lo", out0, 1'b0);

    // Short shift: 5 of 8 bits then update
    shift_bits(0, 8'h10, 5);
    chk("short_cnt", cnt0, 4'd5);
    commit(0);
    chk("short_err", err0, 1'b1);
    chk("short_mem", mem0, 8'h80);
    chk("short_cnt_kept", cnt0, 4'd5);
    chk("short_valid", valid0, 1'b1);

    // Binary NUM_INPUTS=6: value 7 rejected, value 5 accepted
    shift_bits(1, 8'h07, 3);
    commit(1);
    chk("bin7_err", err1, 1'b1);
    chk("bin7_valid", valid1, 1'b0);
    chk("bin7_out", out1, 1'b0);
    chk("bin7_mem", mem1, 3'd0);
    shift_bits(1, 8'h05, 3);
    commit(1);
    chk("bin5_err", err1, 1'b0);
    chk("bin5_valid", valid1, 1'b1);
    chk("bin5_mem", mem1, 3'd5);
    chk("bin5_inv", inv1, 3'd2);
    in1 = 6'b100000; #1;
    chk("bin5_out_hi", out1, 1'b1);
    in1 = 6'b011111; #1;
    chk("bin5_out_lo", out1, 1'b0);

    // Registered output with select 3
    in2 = 8'h08;
    shift_bits(2, 8'h03, 3);
    commit(2);
    chk("reg_mem", mem2, 3'd3);
    chk("reg_out_lag", out2, 1'b0);
    @(posedge prog_clk); #1;
    chk("reg_out_hi", out2, 1'b1);
    in2 = 8'hF7; #1;
    chk("reg_out_hold", out2, 1'b1);
    @(posedge prog_clk); #1;
    chk("reg_out_lo", out2, 1'b0);

    // Chain pass-through: tail is head delayed by 3 shifts
    pat = 8'b10110010;
    for (int k = 0; k < 8; k++) begin
      shift_bits(2, {7'd0, pat[7-k]}, 1);
      if (k >= 2) chk($sformatf("chain_%0d", k), tail2, pat[9-k]);
    end

    // Mid-operation reset after 4 shifts
    in0 = 8'hFF; #1;
    chk("pre_rst_out0", out0, 1'b1);
    shift_bits(0, 8'h0F, 4);
    #2 pReset_n = 1'b0;
    #1;
    chk("mid_rst_mem0", mem0, 8'h00);
    chk("mid_rst_inv0", inv0, 8'hFF);
    chk("mid_rst_out0", out0, 1'b0);
    chk("mid_rst_tail0", tail0, 1'b0);
    chk("mid_rst_cnt0", cnt0, 4'd0);
    chk("mid_rst_valid0", valid0, 1'b0);
    chk("mid_rst_err0", err0, 1'b0);
    chk("mid_rst_out2", out2, 1'b0);
    @(posedge prog_clk); #1;
    pReset_n = 1'b1;
    shift_bits(0, 8'h00, 1);
    chk("fresh_cnt1", cnt0, 4'd1);
    shift_bits(0, 8'h20, 7);
    chk("fresh_cnt8", cnt0, 4'd8);
    commit(0);
    chk("fresh_mem", mem0, 8'h20);
    chk("fresh_valid", valid0, 1'b1);
    chk("fresh_out", out0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_cfgchain_param.md
MUX_CFGCHAIN_PARAM -- requirements
Module: mux_cfgchain_param

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8, number of data inputs, legal range 2..64.
REQ-002 SHALL have parameter ENCODING, default 0, config encoding: 0 = one-hot, 1 = binary.
REQ-003 SHALL have parameter OUT_REG, default 0, output mode: 0 = combinational output, 1 = registered output.
REQ-004 SHALL derive MEM_SIZE = NUM_INPUTS when ENCODING=0, and MEM_SIZE = clog2(NUM_INPUTS) when ENCODING=1; CNT_W = clog2(MEM_SIZE+1).
REQ-005 SHALL have port prog_clk, input, 1, single clock for all state.
REQ-006 SHALL have port pReset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port ccff_head, input, 1, serial configuration data in.
REQ-008 SHALL have port ccff_tail, output, 1, serial configuration data out, for chaining.
REQ-009 SHALL have port shift_en, input, 1, shift strobe for the configuration chain.
REQ-010 SHALL have port update, input, 1, request to commit the shift register to the shadow register.
REQ-011 SHALL have port in, input, NUM_INPUTS, data inputs.
REQ-012 SHALL have port mem, output, MEM_SIZE, committed configuration bits.
REQ-013 SHALL have port mem_inv, output, MEM_SIZE, bitwise complement of mem.
REQ-014 SHALL have port out, output, 1, selected data.
REQ-015 SHALL have port cfg_valid, output, 1, high when a legal configuration is committed.
REQ-016 SHALL have port cfg_err, output, 1, sticky error flag.
REQ-017 SHALL have port shift_cnt, output, CNT_W, number of bits shifted since the last commit or reset.

Function
REQ-018 SHALL, on each prog_clk rising edge with shift_en=1, shift sreg left by one bit, so sreg[0] takes ccff_head and the old sreg[MEM_SIZE-1] is lost.
REQ-019 SHALL drive ccff_tail = sreg[MEM_SIZE-1] combinationally.
REQ-020 SHALL increment shift_cnt by 1 on each shift, saturating at MEM_SIZE; further shifts still move data.
REQ-021 SHALL treat update=1 with shift_en=0 as a commit attempt, evaluated against the current sreg and shift_cnt.
REQ-022 SHALL accept a commit only when shift_cnt==MEM_SIZE and sreg is legal: legal means exactly one bit set (ENCODING=0), or value < NUM_INPUTS (ENCODING=1).
REQ-023 SHALL, on an accepted commit, load shadow<=sreg, set cfg_valid=1, clear cfg_err=0 and clear shift_cnt=0, all on the same edge.
REQ-024 SHALL, on a rejected commit, leave shadow, cfg_valid and shift_cnt unchanged and set cfg_err=1.
REQ-025 SHALL, when update=1 and shift_en=1 in the same cycle, perform the shift, ignore the update and set cfg_err=1.
REQ-026 SHALL drive mem = shadow and mem_inv = ~shadow at all times.
REQ-027 SHALL compute the selection as in[i] where shadow[i]=1 (ENCODING=0), or in[shadow] (ENCODING=1); the selection SHALL be 0 when cfg_valid=0.
REQ-028 SHALL, with OUT_REG=0, drive out combinationally from the selection, with 0-cycle latency.
REQ-029 SHALL, with OUT_REG=1, register the selection on prog_clk, so out follows in with 1-cycle latency.
REQ-030 SHALL switch the new selection in on the same edge that commits, seen combinationally for OUT_REG=0 and one edge later for OUT_REG=1.
REQ-031 SHALL keep cfg_err set until the next accepted commit or reset.

Reset
REQ-032 SHALL, while pReset_n=0, asynchronously clear sreg, shadow, shift_cnt, cfg_valid, cfg_err and the output register to 0.
REQ-033 SHALL therefore, in reset, drive mem=0, mem_inv=all ones, out=0 and ccff_tail=0.
REQ-034 SHALL, on reset asserted mid-shift, discard the partial configuration; the first edge after deassertion is treated as a fresh shift 1.
REQ-035 SHALL sample no inputs on an edge where pReset_n=0.

Verification
REQ-036 SHALL cover one-hot commit (NUM_INPUTS=8, ENCODING=0): shift 8 bits giving sreg=8'b0000_0100, then update -> mem=0x04, mem_inv=0xFB, cfg_valid=1, out=in[2], shift_cnt=0.
REQ-037 SHALL cover binary commit (NUM_INPUTS=6, ENCODING=1, MEM_SIZE=3): shift value 7 then update -> rejected, cfg_err=1, cfg_valid=0, out=0; shift value 5 then update -> out=in[5], cfg_err=0.
REQ-038 SHALL cover short shift: shift 5 of 8 bits then update -> cfg_err=1, shadow unchanged, shift_cnt=5.
REQ-039 SHALL cover simultaneous events: update with shift_en on the 8th shift -> shift_cnt=8, cfg_err=1, no commit; update alone on the next cycle -> commit accepted.
REQ-040 SHALL cover registered output (OUT_REG=1): after commit sel=3, toggling in[3] -> out follows exactly one prog_clk later; chain pass-through: ccff_tail equals ccff_head delayed by MEM_SIZE shifts.
REQ-041 SHALL cover mid-operation reset: pReset_n low between edges after 4 shifts -> all outputs 0 immediately (mem_inv all ones); then 8 fresh shifts and update commit correctly.
